// File: rtl/bbpd_vote.sv
// bbpd_vote: bang-bang phase-detector vote accumulator.
// Each valid sample with a data transition casts a vote from the edge sample.
// A vote is +1 when e_mid == d_now (clock late) and -1 when e_mid == d_prev
// (clock early). The votes are summed over a window of VOTE_LEN valid samples.
// At the end of the window the net sum is compared against +/-THRESH, which
// gives a one-cycle up or dn pulse to the loop filter.
// Optional feature: when the macro BBPD_STALL_DET_EN is defined, a run counter
// is built in. It raises no_trans after NO_TRANS_MAX consecutive valid samples
// with no transition. Without the macro, no_trans is tied to 0.
module bbpd_vote #(
  parameter int VOTE_LEN     = 16,
  parameter int THRESH       = 4,
  parameter int ACC_W        = 6,
  parameter int NO_TRANS_MAX = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_valid,
  input  logic d_now,
  input  logic e_mid,
  output logic up,
  output logic dn,
  output logic no_trans
);

  localparam int CNT_W = (VOTE_LEN > 2) ? $clog2(VOTE_LEN) : 1;
  localparam logic [CNT_W-1:0]        WIN_LAST = CNT_W'(VOTE_LEN - 1);
  localparam logic signed [ACC_W-1:0] TH_P     = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] TH_N     = ACC_W'(-THRESH);
  localparam logic signed [ACC_W-1:0] V_UP     = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] V_DN     = ACC_W'(-1);

  // Reject parameter sets that would make the window or the accumulator invalid
  if (VOTE_LEN < 2) begin : g_chk_len
    $error("bbpd_vote: VOTE_LEN must be >= 2");
  end
  if (THRESH < 1 || THRESH > VOTE_LEN) begin : g_chk_th
    $error("bbpd_vote: THRESH must be in 1..VOTE_LEN");
  end
  if (ACC_W < $clog2(VOTE_LEN + 1) + 1) begin : g_chk_acc
    $error("bbpd_vote: ACC_W too narrow for a full window sum");
  end
  if (NO_TRANS_MAX < 1) begin : g_chk_run
    $error("bbpd_vote: NO_TRANS_MAX must be >= 1");
  end

  logic                    d_prev;
  logic                    prev_valid;
  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] win_cnt;

  logic                    trans;
  logic                    quiet;
  logic                    close;
  logic signed [ACC_W-1:0] vote;
  logic signed [ACC_W-1:0] sum;

  // Classify the current sample and form its vote plus the running sum.
  // The closing sample's vote is included in the sum that is evaluated.
  always_comb begin
    trans = sample_valid && prev_valid && (d_prev != d_now);
    quiet = sample_valid && prev_valid && (d_prev == d_now);
    close = sample_valid && (win_cnt == WIN_LAST);
    vote  = '0;
    if (trans) vote = (e_mid == d_now) ? V_UP : V_DN;
    sum   = acc + vote;
  end

  // History of data samples. prev_valid gates the first post-reset vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_prev     <= 1'b0;
      prev_valid <= 1'b0;
    end else if (sample_valid) begin
      d_prev     <= d_now;
      prev_valid <= 1'b1;
    end
  end

  // Window accumulate/close. The clear and the next window start happen on the
  // same edge, so back-to-back samples lose no throughput at the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (close) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (sample_valid) begin
      acc     <= sum;
      win_cnt <= win_cnt + 1'b1;
    end
  end

  // Registered decision pulses. They last exactly one cycle after the closing
  // sample. THRESH >= 1 makes up and dn mutually exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up <= 1'b0;
      dn <= 1'b0;
    end else begin
      up <= close && (sum >= TH_P);
      dn <= close && (sum <= TH_N);
    end
  end

`ifdef BBPD_STALL_DET_EN
  localparam int RUN_W = $clog2(NO_TRANS_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(NO_TRANS_MAX);

  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;

  // Next run length. It saturates on quiet samples, clears on a transition,
  // and holds on idle cycles.
  always_comb begin
    run_nxt = run_cnt;
    if (trans)                            run_nxt = '0;
    else if (quiet && run_cnt != RUN_MAX) run_nxt = run_cnt + 1'b1;
  end

  // The flag is registered from the next count, so it rises on the same edge
  // where the count reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      no_trans <= 1'b0;
    end else begin
      run_cnt  <= run_nxt;
      no_trans <= (run_nxt == RUN_MAX);
    end
  end
`else
  assign no_trans = 1'b0;
`endif

endmodule

// File: tb/tb_bbpd_vote.sv
// Directed self-checking bench for bbpd_vote at default parameters.
// Inputs change 1 time unit after the rising edge, and outputs are read at
// the same point.
module tb_bbpd_vote;
  logic clk = 1'b0;
  logic rst, sample_valid, d_now, e_mid;
  logic up, dn, no_trans;

  int checks   = 0;
  int failures = 0;
  logic cur = 1'b0;   // expected d_prev held by the bench

  bbpd_vote dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .d_now(d_now), .e_mid(e_mid),
    .up(up), .dn(dn), .no_trans(no_trans)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic d, input logic e);
    sample_valid = v; d_now = d; e_mid = e;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b0; d_now = 1'b0; e_mid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (up !== 1'b0 || dn !== 1'b0 || no_trans !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle up=%b dn=%b nt=%b want 0 0 0", up, dn, no_trans);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (up !== 1'b0 || dn !== 1'b0 || no_trans !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid up=%b dn=%b nt=%b want 0 0 0", up, dn, no_trans);
    end
    rst = 1'b0; sample_valid = 1'b0;
    cur = 1'b0;
  endtask

  // First post-reset sample casts no vote, so the window sum is 15 and up fires.
  task automatic test_up_window();
    logic d, eu;
    for (int i = 0; i < 16; i++) begin
      d = logic'(i % 2);
      step(1'b1, d, d);
      cur = d;
      eu = (i == 15);
      checks++;
      if (up !== eu || dn !== 1'b0) begin
        failures++;
        $display("FAIL up_win[%0d] up=%b dn=%b want %b 0", i, up, dn, eu);
      end
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (up !== 1'b0 || dn !== 1'b0) begin
      failures++;
      $display("FAIL up_win_after up=%b dn=%b want 0 0", up, dn);
    end
  endtask

  // Sixteen early votes (sum -16) produce a dn pulse.
  task automatic test_dn_window();
    logic nd, ed;
    for (int i = 0; i < 16; i++) begin
      nd = ~cur;
      step(1'b1, nd, cur);
      cur = nd;
      ed = (i == 15);
      checks++;
      if (dn !== ed || up !== 1'b0) begin
        failures++;
        $display("FAIL dn_win[%0d] up=%b dn=%b want 0 %b", i, up, dn, ed);
      end
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (up !== 1'b0 || dn !== 1'b0) begin
      failures++;
      $display("FAIL dn_win_after up=%b dn=%b want 0 0", up, dn);
    end
  endtask

  // Threshold edges: +/-3 gives no pulse, +/-4 gives a pulse, and the vote on
  // the closing sample counts. An idle gap mid-window must not disturb anything.
  task automatic test_thresh();
    logic [15:0] masks [5] = '{16'h0007, 16'h000F, 16'h0007, 16'h000F, 16'h8007};
    logic        dirup [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        xup   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        xdn   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] m;
    logic nd, eu, ed;
    for (int c = 0; c < 5; c++) begin
      m = masks[c];
      for (int i = 0; i < 16; i++) begin
        if (i == 8) begin
          step(1'b0, ~cur, 1'b1);
          checks++;
          if (up !== 1'b0 || dn !== 1'b0) begin
            failures++;
            $display("FAIL thresh_idle[%0d] up=%b dn=%b want 0 0", c, up, dn);
          end
        end
        if (m[i]) begin
          nd = ~cur;
          step(1'b1, nd, dirup[c] ? nd : cur);
          cur = nd;
        end else begin
          step(1'b1, cur, logic'(i % 2));
        end
        eu = (i == 15) && xup[c];
        ed = (i == 15) && xdn[c];
        checks++;
        if (up !== eu || dn !== ed) begin
          failures++;
          $display("FAIL thresh[%0d][%0d] up=%b dn=%b want %b %b", c, i, up, dn, eu, ed);
        end
      end
    end
  endtask

  // Votes cast before a mid-window reset are thrown away. The new window needs
  // 16 samples from the first post-reset sample, and a later asynchronous reset
  // clears a live pulse at once.
  task automatic test_reset_mid();
    logic nd, eu;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin nd = ~cur; step(1'b1, nd, nd); cur = nd; end
      else step(1'b1, cur, 1'b0);
    end
    rst = 1'b1; sample_valid = 1'b0;
    #1;
    checks++;
    if (up !== 1'b0 || dn !== 1'b0 || no_trans !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid up=%b dn=%b nt=%b want 0 0 0", up, dn, no_trans);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cur = 1'b0;
    for (int i = 0; i < 16; i++) begin
      nd = ~cur;
      step(1'b1, nd, nd);
      cur = nd;
      eu = (i == 15);
      checks++;
      if (up !== eu || dn !== 1'b0) begin
        failures++;
        $display("FAIL rst_win[%0d] up=%b dn=%b want %b 0", i, up, dn, eu);
      end
    end
    sample_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (up !== 1'b0 || dn !== 1'b0) begin
      failures++;
      $display("FAIL rst_async up=%b dn=%b want 0 0", up, dn);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cur = 1'b0;
  endtask

  // Hold d_now at 1 for 40 samples. When stall detection is built in, no_trans
  // rises after sample 33. One transition then drops it.
  task automatic test_stall();
    logic ent;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, logic'(i % 2));
`ifdef BBPD_STALL_DET_EN
      ent = (i >= 32);
`else
      ent = 1'b0;
`endif
      checks++;
      if (no_trans !== ent || up !== 1'b0 || dn !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d] nt=%b up=%b dn=%b want %b 0 0", i, no_trans, up, dn, ent);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (no_trans !== 1'b0 || up !== 1'b0 || dn !== 1'b0) begin
      failures++;
      $display("FAIL stall_clear nt=%b up=%b dn=%b want 0 0 0", no_trans, up, dn);
    end
  endtask

  initial begin
    test_reset();
    test_up_window();
    test_dn_window();
    test_thresh();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
